// File: rtl/hood_mode_sequencer.sv
// rtl/hood_mode_sequencer.sv - range hood operating-mode FSM with hurricane, exit-delay and self-clean countdowns
module hood_mode_sequencer #(
  parameter int HURRICANE_SEC  = 60,
  parameter int EXIT_DELAY_SEC = 60,
  parameter int CLEAN_SEC      = 180,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             power_on,
  input  logic             btn_menu,
  input  logic             btn_lvl1,
  input  logic             btn_lvl2,
  input  logic             btn_lvl3,
  input  logic             btn_clean,
  output logic [2:0]       state,
  output logic [1:0]       fan_lvl,
  output logic [CNT_W-1:0] countdown,
  output logic             hurricane_used,
  output logic             clean_done
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_MENU    = 3'd2,
    S_LVL1    = 3'd3,
    S_LVL2    = 3'd4,
    S_LVL3    = 3'd5,
    S_EXIT    = 3'd6,
    S_CLEAN   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] HURRICANE_LOAD = CNT_W'(HURRICANE_SEC);
  localparam logic [CNT_W-1:0] EXIT_LOAD      = CNT_W'(EXIT_DELAY_SEC);
  localparam logic [CNT_W-1:0] CLEAN_LOAD     = CNT_W'(CLEAN_SEC);

  state_t st;
  logic   expiry;

  assign state = st;
  // The tick that finds countdown at 1 (or lower, defensively) ends the timed state.
  assign expiry = tick_1hz && (countdown <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= S_OFF;
      fan_lvl        <= 2'd0;
      countdown      <= '0;
      hurricane_used <= 1'b0;
      clean_done     <= 1'b0;
    end else begin
      clean_done <= 1'b0;
      if (!power_on) begin
        st             <= S_OFF;
        fan_lvl        <= 2'd0;
        countdown      <= '0;
        hurricane_used <= 1'b0;
      end else begin
        // Outputs only change on transitions, so each branch sets them for the state it enters.
        case (st)
          S_OFF: begin
            st        <= S_STANDBY;
            fan_lvl   <= 2'd0;
            countdown <= '0;
          end
          S_STANDBY: begin
            if (btn_menu) st <= S_MENU;
          end
          S_MENU: begin
            if (btn_menu) begin
              st <= S_STANDBY;
            end else if (btn_lvl1) begin
              st      <= S_LVL1;
              fan_lvl <= 2'd1;
            end else if (btn_lvl2) begin
              st      <= S_LVL2;
              fan_lvl <= 2'd2;
            end else if (btn_lvl3 && !hurricane_used) begin
              st             <= S_LVL3;
              fan_lvl        <= 2'd3;
              countdown      <= HURRICANE_LOAD;
              hurricane_used <= 1'b1;
            end else if (btn_clean) begin
              st        <= S_CLEAN;
              fan_lvl   <= 2'd0;
              countdown <= CLEAN_LOAD;
            end
          end
          S_LVL1, S_LVL2: begin
            if (btn_menu) begin
              st      <= S_STANDBY;
              fan_lvl <= 2'd0;
            end else if (btn_lvl1) begin
              st      <= S_LVL1;
              fan_lvl <= 2'd1;
            end else if (btn_lvl2) begin
              st      <= S_LVL2;
              fan_lvl <= 2'd2;
            end
          end
          S_LVL3: begin
            // Expiry outranks btn_menu; a tick alongside btn_menu is absorbed by the EXIT load.
            if (expiry) begin
              st        <= S_LVL2;
              fan_lvl   <= 2'd2;
              countdown <= '0;
            end else if (btn_menu) begin
              st        <= S_EXIT;
              fan_lvl   <= 2'd3;
              countdown <= EXIT_LOAD;
            end else if (tick_1hz) begin
              countdown <= countdown - 1'b1;
            end
          end
          S_EXIT: begin
            if (expiry) begin
              st        <= S_STANDBY;
              fan_lvl   <= 2'd0;
              countdown <= '0;
            end else if (tick_1hz) begin
              countdown <= countdown - 1'b1;
            end
          end
          S_CLEAN: begin
            if (expiry) begin
              st         <= S_STANDBY;
              fan_lvl    <= 2'd0;
              countdown  <= '0;
              clean_done <= 1'b1;
            end else if (tick_1hz) begin
              countdown <= countdown - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// tb/tb_hood_mode_sequencer.sv - directed self-checking bench for hood_mode_sequencer
`timescale 1ns/1ps
module tb_hood_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       power_on;
  logic       btn_menu, btn_lvl1, btn_lvl2, btn_lvl3, btn_clean;
  logic [2:0] state;
  logic [1:0] fan_lvl;
  logic [7:0] countdown;
  logic       hurricane_used;
  logic       clean_done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int B_MENU = 0, B_LVL1 = 1, B_LVL2 = 2, B_LVL3 = 3, B_CLEAN = 4;

  hood_mode_sequencer dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .power_on(power_on),
    .btn_menu(btn_menu), .btn_lvl1(btn_lvl1), .btn_lvl2(btn_lvl2),
    .btn_lvl3(btn_lvl3), .btn_clean(btn_clean),
    .state(state), .fan_lvl(fan_lvl), .countdown(countdown),
    .hurricane_used(hurricane_used), .clean_done(clean_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input logic with_tick);
    btn_menu  = (b == B_MENU);
    btn_lvl1  = (b == B_LVL1);
    btn_lvl2  = (b == B_LVL2);
    btn_lvl3  = (b == B_LVL3);
    btn_clean = (b == B_CLEAN);
    tick_1hz  = with_tick;
    step();
    {btn_menu, btn_lvl1, btn_lvl2, btn_lvl3, btn_clean} = '0;
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
    end
  endtask

  task automatic chk_state(input string tag, input int s, input int f, input int c);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".fan"}, 32'(fan_lvl), 32'(f));
    chk({tag, ".cd"}, 32'(countdown), 32'(c));
  endtask

  initial begin
    reset = 1'b0; power_on = 1'b0; tick_1hz = 1'b0;
    {btn_menu, btn_lvl1, btn_lvl2, btn_lvl3, btn_clean} = '0;
    step(); step();
    chk_state("rst", 0, 0, 0);
    chk("rst.hu", 32'(hurricane_used), 0);
    chk("rst.done", 32'(clean_done), 0);

    reset = 1'b1; power_on = 1'b1;
    step();
    chk("pwr.state", 32'(state), 1);

    // reset asserted mid-clean takes effect without a clock edge
    press(B_MENU, 1'b0);
    chk("menu.state", 32'(state), 2);
    press(B_CLEAN, 1'b0);
    chk_state("t1.clean", 7, 0, 180);
    ticks(80);
    chk("t1.cd100", 32'(countdown), 100);
    reset = 1'b0;
    #2;
    chk_state("t1.async", 0, 0, 0);
    chk("t1.done", 32'(clean_done), 0);
    reset = 1'b1;
    step();
    chk("t1.rel", 32'(state), 1);

    // level 1/2 switching, level 3 and clean ignored there
    press(B_MENU, 1'b0);
    press(B_LVL1, 1'b0);
    chk_state("l1", 3, 1, 0);
    press(B_LVL2, 1'b0);
    chk_state("l2", 4, 2, 0);
    press(B_LVL3, 1'b0);
    chk_state("l2.ign3", 4, 2, 0);
    press(B_CLEAN, 1'b0);
    chk("l2.ignclean", 32'(state), 4);
    press(B_LVL1, 1'b0);
    chk_state("l1b", 3, 1, 0);
    press(B_MENU, 1'b0);
    chk_state("l1.menu", 1, 0, 0);
    press(B_LVL1, 1'b0);
    chk("sb.ign", 32'(state), 1);

    // hurricane run and auto-fallback
    press(B_MENU, 1'b0);
    press(B_LVL3, 1'b0);
    chk_state("t2.l3", 5, 3, 60);
    chk("t2.hu", 32'(hurricane_used), 1);
    ticks(59);
    chk_state("t2.59", 5, 3, 1);
    ticks(1);
    chk_state("t2.fb", 4, 2, 0);

    // hurricane locked out until power cycle
    press(B_MENU, 1'b0);
    press(B_MENU, 1'b0);
    chk("t3.menu", 32'(state), 2);
    press(B_LVL3, 1'b0);
    chk_state("t3.lock", 2, 0, 0);
    chk("t3.hu", 32'(hurricane_used), 1);
    power_on = 1'b0;
    step();
    chk_state("t3.off", 0, 0, 0);
    chk("t3.hu0", 32'(hurricane_used), 0);
    power_on = 1'b1;
    step();
    chk("t3.on", 32'(state), 1);
    press(B_MENU, 1'b0);
    press(B_LVL3, 1'b0);
    chk_state("t3.l3", 5, 3, 60);

    // exit delay
    ticks(10);
    chk("t4.cd50", 32'(countdown), 50);
    press(B_MENU, 1'b0);
    chk_state("t4.exit", 6, 3, 60);
    press(B_LVL1, 1'b0);
    chk_state("t4.ign", 6, 3, 60);
    ticks(59);
    chk_state("t4.59", 6, 3, 1);
    ticks(1);
    chk_state("t4.sb", 1, 0, 0);

    // self-clean with one-clk done pulse
    press(B_MENU, 1'b0);
    press(B_CLEAN, 1'b0);
    chk_state("t5.clean", 7, 0, 180);
    press(B_MENU, 1'b0);
    chk("t5.ign", 32'(state), 7);
    ticks(179);
    chk_state("t5.179", 7, 0, 1);
    chk("t5.nodone", 32'(clean_done), 0);
    ticks(1);
    chk_state("t5.sb", 1, 0, 0);
    chk("t5.done", 32'(clean_done), 1);
    step();
    chk("t5.done0", 32'(clean_done), 0);

    // expiry beats btn_menu; tick in load cycle ignored
    power_on = 1'b0;
    step();
    power_on = 1'b1;
    step();
    press(B_MENU, 1'b0);
    press(B_LVL3, 1'b1);
    chk_state("t6.load", 5, 3, 60);
    ticks(59);
    chk("t6.cd1", 32'(countdown), 1);
    press(B_MENU, 1'b1);
    chk_state("t6.race", 4, 2, 0);

    // power loss overrides a timed state
    press(B_MENU, 1'b0);
    press(B_MENU, 1'b0);
    press(B_CLEAN, 1'b0);
    power_on = 1'b0;
    press(B_MENU, 1'b1);
    chk_state("pwroff", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
